// File: rtl/bbc_csr_boot_host.sv
// bbc_csr_boot_host: boot-time CSR writer plus display-write LED capture.
// Latency: one request per table entry, valid rises one cycle after ISSUE is entered; LEDs update one edge after a display write.
// Backpressure: each request is held stable until csr_response__ack or an ACK_TIMEOUT-cycle timeout.
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   start                           reruns the boot table (only honoured in DONE)
//   boot_table__select/address/data packed table, entry i at [W*i +: W]
//   csr_request__*                  registered CSR request bus
//   csr_response__*                 ack and read-data return
//   display_sram_write__*           display write strobe and data
//   leds, activity_led              captured LED bank and stretched activity indicator
//   boot_done, boot_error           sequencer status (error is sticky per run)
//
// Optional feature: define BBC_CSR_BOOT_HOST_READBACK_EN to read back and
// compare every entry after its write is acknowledged.

module bbc_csr_boot_host #(
   parameter int NUM_WRITES     = 4,
   parameter int LED_WIDTH      = 8,
   parameter int ACK_TIMEOUT    = 255,
   parameter int STRETCH_CYCLES = 1023
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [16*NUM_WRITES-1:0]  boot_table__select,
   input  logic [16*NUM_WRITES-1:0]  boot_table__address,
   input  logic [32*NUM_WRITES-1:0]  boot_table__data,
   output logic                      csr_request__valid,
   output logic                      csr_request__read_not_write,
   output logic [15:0]               csr_request__select,
   output logic [15:0]               csr_request__address,
   output logic [31:0]               csr_request__data,
   input  logic                      csr_response__ack,
   input  logic                      csr_response__read_data_valid,
   input  logic [31:0]               csr_response__read_data,
   input  logic                      display_sram_write__enable,
   input  logic [47:0]               display_sram_write__data,
   output logic [LED_WIDTH-1:0]      leds,
   output logic                      activity_led,
   output logic                      boot_done,
   output logic                      boot_error
);

   localparam int IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
   localparam int STR_W = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_WRITES - 1);
   localparam logic [16:0]      TIMEOUT_VAL  = 17'(ACK_TIMEOUT);
   localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_CYCLES);

   typedef enum logic [2:0] {
      ST_ISSUE      = 3'd0,
      ST_WAIT_ACK   = 3'd1,
      ST_DONE       = 3'd2
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
      ,
      ST_READ_ISSUE = 3'd3,
      ST_READ_WAIT  = 3'd4
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [15:0]      timer_q, timer_d;
   logic             vld_q, vld_d;
   logic [15:0]      sel_q, sel_d;
   logic [15:0]      addr_q, addr_d;
   logic [31:0]      dat_q, dat_d;
   logic             err_q, err_d;
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
   logic             rnw_q, rnw_d;
   logic             ack_seen_q, ack_seen_d;
   logic             got_ack;
`endif

   logic [15:0] ent_sel;
   logic [15:0] ent_addr;
   logic [31:0] ent_dat;
   logic [16:0] timer_inc;
   logic [15:0] timer_sat;
   logic        timeout;
   logic        acked;
   logic        advance;

   assign ent_sel  = boot_table__select[16*int'(index_q) +: 16];
   assign ent_addr = boot_table__address[16*int'(index_q) +: 16];
   assign ent_dat  = boot_table__data[32*int'(index_q) +: 32];

   // Timer counts cycles already waited; the timeout fires on the cycle in
   // which the count would reach ACK_TIMEOUT, so valid is held exactly
   // ACK_TIMEOUT cycles. The 16-bit count saturates rather than wrapping.
   assign timer_inc = {1'b0, timer_q} + 17'd1;
   assign timer_sat = (timer_q == 16'hFFFF) ? timer_q : timer_inc[15:0];
   assign timeout   = (timer_inc >= TIMEOUT_VAL);
   // Acks are only meaningful while a request is actually presented.
   assign acked     = vld_q && csr_response__ack;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      timer_d = timer_q;
      vld_d   = vld_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      dat_d   = dat_q;
      err_d   = err_q;
      advance = 1'b0;
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
      rnw_d      = rnw_q;
      ack_seen_d = ack_seen_q;
      got_ack    = 1'b0;
`endif
      case (state_q)
         ST_ISSUE: begin
            vld_d   = 1'b1;
            sel_d   = ent_sel;
            addr_d  = ent_addr;
            dat_d   = ent_dat;
            timer_d = 16'd0;
            state_d = ST_WAIT_ACK;
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
            rnw_d   = 1'b0;
`endif
         end
         ST_WAIT_ACK: begin
            timer_d = timer_sat;
            // Ack is tested first so an ack on the timeout cycle wins.
            if (acked) begin
               vld_d = 1'b0;
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
               state_d = ST_READ_ISSUE;
`else
               advance = 1'b1;
`endif
            end else if (timeout) begin
               vld_d   = 1'b0;
               err_d   = 1'b1;
               advance = 1'b1;
            end
         end
         ST_DONE: begin
            vld_d = 1'b0;
            if (start) begin
               err_d   = 1'b0;
               index_d = '0;
               state_d = ST_ISSUE;
            end
         end
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
         ST_READ_ISSUE: begin
            // Select and address are still held from the write.
            vld_d      = 1'b1;
            rnw_d      = 1'b1;
            dat_d      = 32'd0;
            timer_d    = 16'd0;
            ack_seen_d = 1'b0;
            state_d    = ST_READ_WAIT;
         end
         ST_READ_WAIT: begin
            timer_d = timer_sat;
            if (acked) begin
               vld_d      = 1'b0;
               ack_seen_d = 1'b1;
            end
            got_ack = ack_seen_q || acked;
            if (got_ack && csr_response__read_data_valid) begin
               if (csr_response__read_data != ent_dat) err_d = 1'b1;
               vld_d   = 1'b0;
               advance = 1'b1;
            end else if (timeout) begin
               err_d   = 1'b1;
               vld_d   = 1'b0;
               advance = 1'b1;
            end
         end
`endif
         default: begin
            vld_d   = 1'b0;
            state_d = ST_ISSUE;
         end
      endcase

      if (advance) begin
`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
         rnw_d = 1'b0;
`endif
         if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
         end else begin
            index_d = index_q + IDX_W'(1);
            state_d = ST_ISSUE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ISSUE;
         index_q <= '0;
         timer_q <= 16'd0;
         vld_q   <= 1'b0;
         sel_q   <= 16'd0;
         addr_q  <= 16'd0;
         dat_q   <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         timer_q <= timer_d;
         vld_q   <= vld_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         err_q   <= err_d;
      end
   end

`ifdef BBC_CSR_BOOT_HOST_READBACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rnw_q      <= 1'b0;
         ack_seen_q <= 1'b0;
      end else begin
         rnw_q      <= rnw_d;
         ack_seen_q <= ack_seen_d;
      end
   end

   assign csr_request__read_not_write = rnw_q;
`else
   assign csr_request__read_not_write = 1'b0;

   logic unused_read_rsp;
   assign unused_read_rsp = ^{csr_response__read_data_valid, csr_response__read_data};
`endif

   assign csr_request__valid   = vld_q;
   assign csr_request__select  = sel_q;
   assign csr_request__address = addr_q;
   assign csr_request__data    = dat_q;
   assign boot_done            = (state_q == ST_DONE);
   assign boot_error           = err_q;

   // LED capture and activity stretcher, independent of the sequencer.
   logic [LED_WIDTH-1:0] leds_q;
   logic [STR_W-1:0]     str_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds_q <= '0;
         str_q  <= '0;
      end else if (display_sram_write__enable) begin
         leds_q <= display_sram_write__data[LED_WIDTH-1:0];
         str_q  <= STRETCH_LOAD;
      end else if (str_q != '0) begin
         str_q <= str_q - STR_W'(1);
      end
   end

   assign leds         = leds_q;
   assign activity_led = (str_q != '0);

   // Bits above LED_WIDTH are intentionally discarded.
   logic unused_disp_bits;
   assign unused_disp_bits = ^display_sram_write__data;

endmodule

// File: doc/bbc_csr_boot_host.md
Name: bbc_csr_boot_host

Overview:
- Board-level host agent sitting beside bbc_micro_with_rams; replaces constant tie-offs on the csr_request bus.
- After reset, or on a start pulse, issues a parametrised list of CSR writes and waits for each csr_response ack; a timeout bounds each wait.
- Also captures display_sram_write traffic into a registered, width-parametrised LED bank, with an activity stretcher.

Parameters:
- NUM_WRITES, 4, number of boot CSR writes in the table (1..16).
- LED_WIDTH, 8, LED bank width; taken from display_sram_write__data[LED_WIDTH-1:0] (1..48).
- ACK_TIMEOUT, 255, cycles to wait for csr_response__ack before abandoning an access (1..65535).
- STRETCH_CYCLES, 1023, cycles activity_led stays on after the last display write.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; reruns the boot table when sequencer is in DONE.
- boot_table__select  in  16*NUM_WRITES  entry i at bits [16i+15:16i].
- boot_table__address  in  16*NUM_WRITES  per-entry CSR address.
- boot_table__data  in  32*NUM_WRITES  per-entry write data.
- csr_request__valid  out  1  request valid.
- csr_request__read_not_write  out  1  1=read, 0=write.
- csr_request__select  out  16  CSR select.
- csr_request__address  out  16  CSR address.
- csr_request__data  out  32  write data.
- csr_response__ack  in  1  request accepted.
- csr_response__read_data_valid  in  1  read data valid.
- csr_response__read_data  in  32  read data.
- display_sram_write__enable  in  1  display write strobe.
- display_sram_write__data  in  48  display write data.
- leds  out  LED_WIDTH  last captured display data.
- activity_led  out  1  stretched display-write activity.
- boot_done  out  1  high in DONE.
- boot_error  out  1  sticky: any timeout (or readback mismatch) in the current run.

Behaviour:
- Reset values: all csr_request__* 0; leds 0; activity_led 0; boot_done 0; boot_error 0; state ISSUE; index 0; timer 0.
- States: ISSUE, WAIT_ACK, DONE. READ_ISSUE and READ_WAIT exist only with the optional feature.
- ISSUE: drive entry[index] with valid=1 and read_not_write=0; clear timer; go to WAIT_ACK next cycle. Valid is asserted in the cycle after ISSUE is entered.
- WAIT_ACK: hold valid and all fields stable until an ack is sampled.
  - On ack: drop valid in the next cycle; index+1; go to ISSUE, or to DONE if index==NUM_WRITES-1.
  - If the timer reaches ACK_TIMEOUT with no ack: set boot_error; drop valid; advance exactly as for an ack.
  - Ack and timeout in the same cycle: ack wins; boot_error is not set.
- Back-to-back requests have at least one cycle of valid=0 between them.
- DONE: valid=0; boot_done=1.
  - start=1: clear boot_done, boot_error and index, then go to ISSUE.
  - start outside DONE is ignored.
- Ack sampled while valid=0 is ignored.
- Reset asserted mid-transaction: valid drops asynchronously; the sequence restarts from index 0 after release.
- Timer is 16 bits and saturates; it never wraps.
- LED path: on display_sram_write__enable, leds <= data[LED_WIDTH-1:0] on the next edge.
  - The same edge loads the stretch counter with STRETCH_CYCLES.
  - activity_led = (counter != 0); the counter decrements to 0 and stops there.
  - An enable that arrives while the counter is nonzero reloads it.
- The LED path runs independently of the sequencer state.

Optional Feature:
- Macro: BBC_CSR_BOOT_HOST_READBACK_EN.
- Defined: after each write ack, go to READ_ISSUE. Issue a read (read_not_write=1, same select and address, data=0) and wait in READ_WAIT.
  - READ_WAIT needs the ack, then read_data_valid, both within ACK_TIMEOUT of READ_ISSUE.
  - Compare read_data with the table data; a mismatch or timeout sets boot_error. Then advance as normal.
- Undefined: no reads are ever issued; read_not_write is tied 0; response read_data ports are unused.

Test Plan:
- NUM_WRITES=4; ack 2 cycles after each valid → exactly 4 writes in table order with correct select, address and data; boot_done=1; boot_error=0; valid low between requests.
- Entry 1 never acked; ACK_TIMEOUT=8 → valid held 8 cycles then dropped; entries 2 and 3 still issued; boot_error=1; boot_done=1.
- Ack on exactly the timeout cycle → no error; next entry issued.
- Reset pulsed while WAIT_ACK on entry 2 → valid=0 immediately; after release entry 0 is reissued.
- Display writes of data 0x..A5 then 0x..3C 5 cycles apart, STRETCH_CYCLES=10 → leds=0xA5 then 0x3C; activity_led high until 10 cycles after the second write.
- READBACK_EN: entry 0 read returns data+1 → boot_error=1; matching reads leave boot_error=0.
